commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
Synthesizable retirement-trace capture for the pipelined CPU; a hardware successor to the per-cycle pc/instr/regfile text dump. Snoops the writeback-stage commit port, packs each retired instruction into a record and buffers it in a parametrised FIFO. A debug reader drains the FIFO through a valid/ready port. Adds a capture-count limit, a write-only filter mode and overflow accounting.

Parameters:
XLEN, 32, data and PC width
DEPTH, 64, FIFO entries; power of two, >= 2
MAX_RECORDS, 5000, records captured before auto-stop; 0 = unlimited
FILTER_MODE, 0, 0 = capture every commit; 1 = capture only commits with an effective register write
CNT_W, 16, width of the captured and dropped counters

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, synchronous, active-low
trace_en  in  1  capture enable, level
commit_valid  in  1  one instruction retires this cycle
commit_pc  in  XLEN  PC of the retiring instruction
commit_inst  in  32  instruction word
commit_we  in  1  register-file write enable
commit_waddr  in  5  destination register
commit_wdata  in  XLEN  write-back data
rd_valid  out  1  FIFO head valid
rd_ready  in  1  reader accepts the head
rd_data  out  REC_W  head record (layout in Behaviour)
level  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky; set when a record was dropped
dropped  out  CNT_W  dropped-record count, saturating
captured  out  CNT_W  accepted-record count, saturating
done  out  1  MAX_RECORDS reached

Behaviour:
- Reset (rst==0 at a posedge): FIFO empty; rd_valid=0; rd_data=0; level=0; overflow=0; dropped=0; captured=0; done=0; state=IDLE. Reset takes priority over every other event, including a reset in mid-capture or mid-drain.
- Effective write: eff_we = commit_we && (commit_waddr != 0).
- Record layout, MSB to LSB: {commit_pc, commit_inst, eff_we, commit_waddr, commit_wdata or 0 when !eff_we}. REC_W = 2*XLEN+38. Width grows with the optional feature.
- Qualify: qual = commit_valid && state==RUN && (FILTER_MODE==0 || eff_we).
- State machine:
  - IDLE -> RUN when trace_en=1.
  - RUN -> IDLE when trace_en=0.
  - RUN -> STOP when the accepted record makes captured == MAX_RECORDS (MAX_RECORDS != 0). done=1 from the following cycle.
  - STOP is held until reset. trace_en is ignored in STOP. The FIFO remains readable in STOP.
- Push: a qual record is written on the same posedge. rd_valid rises the cycle after a push into an empty FIFO, so latency is 1.
- Pop: occurs when rd_valid && rd_ready. rd_data is the registered head and updates on the posedge after the pop.
- Full, no pop: a qual record is dropped. overflow is set, dropped is incremented, captured is not incremented.
- Full with a simultaneous pop: the push is accepted and level is unchanged.
- Empty with rd_ready asserted: no effect.
- Counters saturate at 2^CNT_W-1. Read and write pointers wrap modulo DEPTH.
- level counts 0..DEPTH.
- A dropped record does not count toward MAX_RECORDS.

Optional Feature:
Macro: COMMIT_TRACE_TIMESTAMP_EN.
- Defined: a 32-bit free-running cycle counter is instantiated. It is reset to 0, increments every cycle and wraps. Its value at the push is appended as the LSBs of the record: REC_W = 2*XLEN+70.
- Undefined: no counter exists and the record layout is exactly as given in Behaviour.

Decomposition:
- Shared package trace_pkg holds:
  - record field offsets and the REC_W formula
  - state encoding: IDLE=2'd0, RUN=2'd1, STOP=2'd2
  - the FILTER_MODE constants
- One sub-module, trace_fifo: parametrised synchronous FIFO (width, depth) providing full, empty and level. The FSM, filter, counters and record packing stay in the top module.

Test Plan:
- Reset and basic capture: reset, trace_en=1, commit pc=0x00400000 inst=0x20080005 we=1 waddr=8 wdata=5 -> next cycle rd_valid=1 with those fields and eff_we=1; captured=1.
- x0 write and filter: FILTER_MODE=1; commits with waddr=0 we=1, then we=0, then waddr=9 we=1 -> only the waddr=9 record is captured; captured=1.
- Overflow: DEPTH=4, rd_ready=0, 6 commits -> level=4, overflow=1, dropped=2. Draining returns the first 4 PCs in order.
- Full with pop: full FIFO, rd_ready=1 and commit_valid=1 in the same cycle -> level stays 4, dropped unchanged, FIFO order preserved.
- Limit: MAX_RECORDS=3, 5 commits -> captured=3, done=1 after the third record. Later commits are ignored. The 3 records remain readable.
- Mid-run reset: rst=0 for one cycle with level=3 -> level=0, rd_valid=0, all counters 0. Capture resumes once trace_en=1.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the commit trace buffer.
//   - FSM state encoding (IDLE / RUN / STOP)
//   - filter mode constants and the filter predicate
//   - record field widths, offsets and the REC_W formula
// Optional feature macro: COMMIT_TRACE_TIMESTAMP_EN appends a 32-bit
// cycle timestamp as the record LSBs (all other fields shift up by TS_W).
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } trace_state_e;

    localparam int unsigned FILTER_ALL    = 0;
    localparam int unsigned FILTER_WRITES = 1;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
    localparam int unsigned TS_W = 32;
`else
    localparam int unsigned TS_W = 0;
`endif

    localparam int unsigned INST_W  = 32;
    localparam int unsigned WADDR_W = 5;

    // Record, MSB to LSB: {pc, inst, eff_we, waddr, wdata[, timestamp]}
    localparam int unsigned OFF_WDATA = TS_W;

    function automatic int unsigned off_waddr(input int unsigned xlen);
        return OFF_WDATA + xlen;
    endfunction

    function automatic int unsigned off_we(input int unsigned xlen);
        return off_waddr(xlen) + WADDR_W;
    endfunction

    function automatic int unsigned off_inst(input int unsigned xlen);
        return off_we(xlen) + 1;
    endfunction

    function automatic int unsigned off_pc(input int unsigned xlen);
        return off_inst(xlen) + INST_W;
    endfunction

    function automatic int unsigned rec_w(input int unsigned xlen);
        return 2 * xlen + 38 + TS_W;
    endfunction

    function automatic logic filter_pass(input int unsigned mode, input logic eff_we);
        return (mode == FILTER_ALL) || ((mode == FILTER_WRITES) && eff_we);
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// commit_trace_buffer_if: writeback commit snoop port plus the debug read port.
//   commit_valid/pc/inst/we/waddr/wdata : commit side, driven by the CPU
//   rd_valid/rd_data                    : FIFO head, driven by the buffer
//   rd_ready                            : reader accepts the head
// Modports: master = CPU/reader side, slave = trace buffer side.
interface commit_trace_buffer_if #(
    parameter int unsigned XLEN = 32
);
    import trace_pkg::*;

    localparam int unsigned REC_W = rec_w(XLEN);

    logic              commit_valid;
    logic [XLEN-1:0]   commit_pc;
    logic [INST_W-1:0] commit_inst;
    logic              commit_we;
    logic [WADDR_W-1:0] commit_waddr;
    logic [XLEN-1:0]   commit_wdata;
    logic              rd_valid;
    logic              rd_ready;
    logic [REC_W-1:0]  rd_data;

    modport master (
        output commit_valid, commit_pc, commit_inst, commit_we, commit_waddr, commit_wdata,
        output rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  commit_valid, commit_pc, commit_inst, commit_we, commit_waddr, commit_wdata,
        input  rd_ready,
        output rd_valid, rd_data
    );

endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO, power-of-two DEPTH.
//   clk, rst (sync, active-low)
//   push/wdata : write request; accepted when not full, or full with a pop
//   pop        : read request; ignored when empty
//   rdata      : registered head, forced to 0 while empty
//   full, empty, level (0..DEPTH)
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_en, rd_en;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + (AW+1)'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - (AW+1)'(1);
        end
        rdata = empty ? '0 : mem_q[rd_ptr_q];
        level = count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the empty gate on rdata hides stale entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: retirement trace capture.
// Packs each qualifying commit into a record and buffers it for a debug reader.
//   clk, rst (sync, active-low), trace_en (capture enable, level)
//   bus      : commit snoop + rd_valid/rd_ready/rd_data read port (slave)
//   level    : FIFO occupancy
//   overflow : sticky, a qualifying record was dropped on a full FIFO
//   dropped  : saturating dropped-record count
//   captured : saturating accepted-record count
//   done     : MAX_RECORDS reached (capture stopped until reset)
// Optional feature macro: COMMIT_TRACE_TIMESTAMP_EN (32-bit cycle counter
// value at push appended as the record LSBs).
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned MAX_RECORDS = 5000,
    parameter int unsigned FILTER_MODE = FILTER_ALL,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    commit_trace_buffer_if.slave     bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         dropped,
    output logic [CNT_W-1:0]         captured,
    output logic                     done
);
    localparam int unsigned REC_W     = rec_w(XLEN);
    localparam int unsigned OFF_WADDR = off_waddr(XLEN);
    localparam int unsigned OFF_WE    = off_we(XLEN);
    localparam int unsigned OFF_INST  = off_inst(XLEN);
    localparam int unsigned OFF_PC    = off_pc(XLEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    trace_state_e     state_q, state_d;
    logic [CNT_W-1:0] captured_q, captured_d;
    logic [CNT_W-1:0] dropped_q, dropped_d;
    logic             overflow_q, overflow_d;
    logic             eff_we, qual, pop, accept, drop, limit_hit;
    logic             fifo_full, fifo_empty;
    logic [REC_W-1:0] record;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]  ts_q, ts_d;
`endif

    always_comb begin
        eff_we     = bus.commit_we && (bus.commit_waddr != '0);
        qual       = bus.commit_valid && (state_q == RUN) && filter_pass(FILTER_MODE, eff_we);
        pop        = !fifo_empty && bus.rd_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        accept     = qual && (!fifo_full || pop);
        drop       = qual && fifo_full && !pop;
        captured_d = captured_q;
        dropped_d  = dropped_q;
        overflow_d = overflow_q || drop;
        if (accept && (captured_q != CNT_MAX)) begin
            captured_d = captured_q + CNT_W'(1);
        end
        if (drop && (dropped_q != CNT_MAX)) begin
            dropped_d = dropped_q + CNT_W'(1);
        end
        limit_hit = accept && (MAX_RECORDS != 0) && (32'(captured_d) == MAX_RECORDS);
    end

    always_comb begin
        record = '0;
        record[OFF_PC +: XLEN]         = bus.commit_pc;
        record[OFF_INST +: INST_W]     = bus.commit_inst;
        record[OFF_WE]                 = eff_we;
        record[OFF_WADDR +: WADDR_W]   = bus.commit_waddr;
        record[OFF_WDATA +: XLEN]      = eff_we ? bus.commit_wdata : '0;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        record[0 +: TS_W]              = ts_q;
`endif
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (trace_en) state_d = RUN;
            RUN: begin
                if (limit_hit) begin
                    state_d = STOP;
                end else if (!trace_en) begin
                    state_d = IDLE;
                end
            end
            STOP:    state_d = STOP;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        done = (state_q == STOP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            captured_q <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            captured_q <= captured_d;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef COMMIT_TRACE_TIMESTAMP_EN
    always_comb begin
        ts_d = ts_q + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end
`endif

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .wdata (record),
        .rdata (bus.rd_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        bus.rd_valid = !fifo_empty;
        overflow     = overflow_q;
        dropped      = dropped_q;
        captured     = captured_q;
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer. Two instances share the commit stimulus:
//   u0: DEPTH=4, unlimited, capture all commits, 4-bit counters
//   u1: DEPTH=4, MAX_RECORDS=3, capture register writes only, 16-bit counters
// A queue-based model predicts every output; a negedge process compares.
module tb_commit_trace_buffer;
    localparam int XLEN = 32;
    localparam int DEPTH = 4;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    localparam int TS_W = 32;
`else
    localparam int TS_W = 0;
`endif
    localparam int REC_W = 2 * XLEN + 38 + TS_W;

    typedef logic [REC_W-1:0] rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_en;
    logic [1:0]  rr;
    logic        cv, cwe;
    logic [31:0] cpc, cinst, cwd;
    logic [4:0]  cwa;

    logic [2:0]  lvl0, lvl1;
    logic        ovf0, ovf1, done0, done1;
    logic [3:0]  drp0, cap0;
    logic [15:0] drp1, cap1;

    int n_chk = 0;
    int n_fail = 0;

    // model state
    rec_t        mq [2][$];
    int          m_cap [2];
    int          m_drop [2];
    bit          m_ovf [2];
    bit          m_run [2];
    bit          m_stop [2];
    int unsigned m_ts = 0;

    localparam logic [101:0] BASIC_REC = {32'h00400000, 32'h20080005, 1'b1, 5'd8, 32'd5};
    logic [31:0] exp0 [4] = '{32'h1004, 32'h1008, 32'h100C, 32'h2000};

    commit_trace_buffer_if #(.XLEN(XLEN)) bus0 ();
    commit_trace_buffer_if #(.XLEN(XLEN)) bus1 ();

    always_comb begin
        bus0.commit_valid = cv;  bus1.commit_valid = cv;
        bus0.commit_pc    = cpc; bus1.commit_pc    = cpc;
        bus0.commit_inst  = cinst; bus1.commit_inst = cinst;
        bus0.commit_we    = cwe; bus1.commit_we    = cwe;
        bus0.commit_waddr = cwa; bus1.commit_waddr = cwa;
        bus0.commit_wdata = cwd; bus1.commit_wdata = cwd;
        bus0.rd_ready     = rr[0];
        bus1.rd_ready     = rr[1];
    end

    commit_trace_buffer #(
        .XLEN(XLEN), .DEPTH(DEPTH), .MAX_RECORDS(0), .FILTER_MODE(0), .CNT_W(4)
    ) dut0 (
        .clk(clk), .rst(rst), .trace_en(trace_en), .bus(bus0), .level(lvl0),
        .overflow(ovf0), .dropped(drp0), .captured(cap0), .done(done0)
    );

    commit_trace_buffer #(
        .XLEN(XLEN), .DEPTH(DEPTH), .MAX_RECORDS(3), .FILTER_MODE(1), .CNT_W(16)
    ) dut1 (
        .clk(clk), .rst(rst), .trace_en(trace_en), .bus(bus1), .level(lvl1),
        .overflow(ovf1), .dropped(drp1), .captured(cap1), .done(done1)
    );

    always #5 clk = ~clk;

    function automatic int cfg_max(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic bit cfg_filt(input int i);
        return (i == 1);
    endfunction

    function automatic int cfg_cmax(input int i);
        return (i == 0) ? 15 : 65535;
    endfunction

    function automatic rec_t pack(input logic [31:0] pc, input logic [31:0] inst, input logic ew,
                                  input logic [4:0] wa, input logic [31:0] wd, input int unsigned ts);
        logic [101:0] base;
        base = {pc, inst, ew, wa, ew ? wd : 32'd0};
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        return {base, ts[31:0]};
`else
        if (ts > 0) begin end
        return base;
`endif
    endfunction

    function automatic rec_t head(input int i);
        if (mq[i].size() == 0) return '0;
        return mq[i][0];
    endfunction

    task automatic check(input string name, input rec_t act, input rec_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs that edge samples.
    task automatic model_advance();
        bit ew, pop, qual;
        ew = cwe && (cwa != 5'd0);
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                mq[i].delete();
                m_run[i] = 0; m_stop[i] = 0; m_ovf[i] = 0;
                m_drop[i] = 0; m_cap[i] = 0;
            end else begin
                pop  = (mq[i].size() != 0) && rr[i];
                qual = cv && m_run[i] && (!cfg_filt(i) || ew);
                if (pop) mq[i].delete(0);
                if (qual) begin
                    if (mq[i].size() < DEPTH) begin
                        mq[i].push_back(pack(cpc, cinst, ew, cwa, cwd, m_ts));
                        if (m_cap[i] < cfg_cmax(i)) m_cap[i]++;
                        if (cfg_max(i) != 0 && m_cap[i] == cfg_max(i)) m_stop[i] = 1;
                    end else begin
                        m_ovf[i] = 1;
                        if (m_drop[i] < cfg_cmax(i)) m_drop[i]++;
                    end
                end
                m_run[i] = !m_stop[i] && trace_en;
            end
        end
        m_ts = rst ? m_ts + 1 : 0;
    endtask

    task automatic compare_all();
        check("u0.rd_valid", rec_t'(bus0.rd_valid), rec_t'(mq[0].size() != 0));
        check("u0.rd_data",  bus0.rd_data, head(0));
        check("u0.level",    rec_t'(lvl0), rec_t'(mq[0].size()));
        check("u0.overflow", rec_t'(ovf0), rec_t'(m_ovf[0]));
        check("u0.dropped",  rec_t'(drp0), rec_t'(m_drop[0]));
        check("u0.captured", rec_t'(cap0), rec_t'(m_cap[0]));
        check("u0.done",     rec_t'(done0), rec_t'(m_stop[0]));
        check("u1.rd_valid", rec_t'(bus1.rd_valid), rec_t'(mq[1].size() != 0));
        check("u1.rd_data",  bus1.rd_data, head(1));
        check("u1.level",    rec_t'(lvl1), rec_t'(mq[1].size()));
        check("u1.overflow", rec_t'(ovf1), rec_t'(m_ovf[1]));
        check("u1.dropped",  rec_t'(drp1), rec_t'(m_drop[1]));
        check("u1.captured", rec_t'(cap1), rec_t'(m_cap[1]));
        check("u1.done",     rec_t'(done1), rec_t'(m_stop[1]));
    endtask

    // Outputs are stable at negedge; inputs seen here are what the next posedge samples.
    initial begin
        forever begin
            @(negedge clk);
            compare_all();
            model_advance();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cv = 0; cwe = 0; cwa = '0; cpc = '0; cinst = '0; cwd = '0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                          input logic [4:0] wa, input logic [31:0] wd);
        cv = 1; cpc = pc; cinst = inst; cwe = we; cwa = wa; cwd = wd;
    endtask

    initial begin
        int bias;
        rst = 0; trace_en = 0; rr = '0;
        idle_in();
        tick();
        check("reset.level",    rec_t'(lvl0), 0);
        check("reset.rd_valid", rec_t'(bus0.rd_valid), 0);
        check("reset.rd_data",  bus0.rd_data, 0);
        check("reset.captured", rec_t'(cap0), 0);
        check("reset.overflow", rec_t'(ovf0), 0);
        check("reset.done1",    rec_t'(done1), 0);

        // basic capture
        rst = 1; trace_en = 1;
        tick();
        commit(32'h00400000, 32'h20080005, 1'b1, 5'd8, 32'd5);
        tick();
        idle_in();
        check("basic.rd_valid",   rec_t'(bus0.rd_valid), 1);
        check("basic.record",     rec_t'(bus0.rd_data >> TS_W), rec_t'(BASIC_REC));
        check("basic.model_pin",  rec_t'(head(0) >> TS_W), rec_t'(BASIC_REC));
        check("basic.captured0",  rec_t'(cap0), 1);
        check("basic.captured1",  rec_t'(cap1), 1);

        // x0 write and write-only filter
        rst = 0; tick(); rst = 1; tick();
        commit(32'h10, 32'h1, 1'b1, 5'd0, 32'h11); tick();
        commit(32'h14, 32'h2, 1'b0, 5'd5, 32'h22); tick();
        commit(32'h18, 32'h3, 1'b1, 5'd9, 32'h33); tick();
        idle_in();
        check("filter.captured1", rec_t'(cap1), 1);
        check("filter.captured0", rec_t'(cap0), 3);
        check("filter.head1",     rec_t'(bus1.rd_data[TS_W +: 38]), rec_t'({1'b1, 5'd9, 32'h33}));
        check("filter.head0_x0",  rec_t'(bus0.rd_data[TS_W +: 38]), rec_t'({1'b0, 5'd0, 32'h0}));
        check("filter.level0",    rec_t'(lvl0), 3);

        // mid-run reset with three entries buffered
        rst = 0; tick(); rst = 1;
        check("midrst.level",    rec_t'(lvl0), 0);
        check("midrst.rd_valid", rec_t'(bus0.rd_valid), 0);
        check("midrst.captured", rec_t'(cap0), 0);
        check("midrst.dropped",  rec_t'(drp0), 0);
        check("midrst.overflow", rec_t'(ovf0), 0);
        tick();
        commit(32'h40, 32'h4, 1'b1, 5'd3, 32'h44); tick();
        idle_in();
        check("midrst.resume", rec_t'(cap0), 1);

        // overflow on u0, capture limit on u1
        rst = 0; tick(); rst = 1; tick();
        for (int k = 0; k < 6; k++) begin
            commit(32'h1000 + 32'(4 * k), 32'(k), 1'b1, 5'(k + 1), 32'(3 * k));
            tick();
            check($sformatf("limit.done_k%0d", k), rec_t'(done1), rec_t'(k >= 2));
        end
        idle_in();
        check("ovf.level",    rec_t'(lvl0), 4);
        check("ovf.overflow", rec_t'(ovf0), 1);
        check("ovf.dropped",  rec_t'(drp0), 2);
        check("ovf.captured", rec_t'(cap0), 4);
        check("limit.captured", rec_t'(cap1), 3);
        check("limit.level",    rec_t'(lvl1), 3);

        // full with simultaneous pop
        rr[0] = 1;
        commit(32'h2000, 32'h9, 1'b1, 5'd7, 32'h77);
        tick();
        idle_in(); rr[0] = 0;
        check("fullpop.level",    rec_t'(lvl0), 4);
        check("fullpop.dropped",  rec_t'(drp0), 2);
        check("fullpop.captured", rec_t'(cap0), 5);
        check("limit.ignored",    rec_t'(cap1), 3);

        // drain both
        rr = 2'b11;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("drain0.pc%0d", j), rec_t'(bus0.rd_data[REC_W-1 -: 32]), rec_t'(exp0[j]));
            if (j < 3) check($sformatf("drain1.pc%0d", j), rec_t'(bus1.rd_data[REC_W-1 -: 32]), rec_t'(32'h1000 + 32'(4 * j)));
            tick();
        end
        check("drain.level0", rec_t'(lvl0), 0);
        check("drain.level1", rec_t'(lvl1), 0);
        check("drain.done1",  rec_t'(done1), 1);

        // randomized traffic with varying reader pressure
        rst = 0; tick();
        for (int n = 0; n < 3000; n++) begin
            bias     = (n / 250) % 5;
            rst      = ($urandom_range(0, 299) != 0);
            trace_en = ($urandom_range(0, 15) != 0);
            cv       = ($urandom_range(0, 3) != 0);
            cwe      = 1'($urandom_range(0, 1));
            cwa      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            cpc      = $urandom;
            cinst    = $urandom;
            cwd      = $urandom;
            rr[0]    = ($urandom_range(0, 3) < bias);
            rr[1]    = ($urandom_range(0, 3) < bias);
            tick();
        end
        idle_in(); rr = '0; rst = 1;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
